// File: rtl/pulse_conditioner_if.sv
// rtl/pulse_conditioner_if.sv - channel, strobe and status bundle for the pulse conditioner
//
// Purpose: groups the per-channel raw inputs, the shared sample/clear strobes
// and the conditioned outputs so that the conditioner and the counter block
// can share one port declaration.
//
// Signals:
//   i_channels  [N] raw asynchronous channel inputs
//   i_sample_en     filter sample strobe (tie high to sample every cycle)
//   i_act_clr       one-cycle clear of all activity flags
//   o_level     [N] filtered channel levels
//   o_pulse     [N] one-cycle strobe on each filtered rising edge
//   o_activity  [N] sticky per-channel activity flags
//
// Modports:
//   master - the side that drives the inputs and observes the outputs
//   slave  - the conditioner itself
interface pulse_conditioner_if #(
    parameter int NUMBER_OF_CHANNELS = 16
);
    logic [NUMBER_OF_CHANNELS-1:0] i_channels;
    logic                          i_sample_en;
    logic                          i_act_clr;
    logic [NUMBER_OF_CHANNELS-1:0] o_level;
    logic [NUMBER_OF_CHANNELS-1:0] o_pulse;
    logic [NUMBER_OF_CHANNELS-1:0] o_activity;

    modport master (
        output i_channels,
        output i_sample_en,
        output i_act_clr,
        input  o_level,
        input  o_pulse,
        input  o_activity
    );

    modport slave (
        input  i_channels,
        input  i_sample_en,
        input  i_act_clr,
        output o_level,
        output o_pulse,
        output o_activity
    );
endinterface

// File: rtl/pulse_conditioner.sv
// rtl/pulse_conditioner.sv - per-channel synchronizer, glitch filter, rising-edge strobe and activity flag
//
// Purpose: conditions raw field pulse inputs before they reach the channel
// counters. Each channel is synchronized with two flops, then filtered so
// that the level only changes after FILTER_LENGTH consecutive enabled samples
// disagree with it. A filtered 0->1 transition produces a single-cycle strobe
// and sets a sticky activity flag.
//
// Ports:
//   i_clk    - block clock
//   i_rst_n  - asynchronous active-low reset, clears every register
//   bus      - pulse_conditioner_if.slave carrying i_channels, i_sample_en,
//              i_act_clr, o_level, o_pulse, o_activity
//
// Parameters:
//   NUMBER_OF_CHANNELS - independent channel count
//   FILTER_LENGTH      - consecutive differing samples needed for a level change (1..255)
//   FILTER_CNT_WIDTH   - filter counter width, 2**FILTER_CNT_WIDTH > FILTER_LENGTH
module pulse_conditioner #(
    parameter int NUMBER_OF_CHANNELS = 16,
    parameter int FILTER_LENGTH      = 4,
    parameter int FILTER_CNT_WIDTH   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    pulse_conditioner_if.slave    bus
);

    localparam logic [FILTER_CNT_WIDTH-1:0] LP_CNT_LAST = FILTER_CNT_WIDTH'(FILTER_LENGTH - 1);

    logic [NUMBER_OF_CHANNELS-1:0] r_sync1;
    logic [NUMBER_OF_CHANNELS-1:0] r_sync2;
    logic [NUMBER_OF_CHANNELS-1:0] r_lvl;
    logic [FILTER_CNT_WIDTH-1:0]   r_cnt [NUMBER_OF_CHANNELS];
    logic [NUMBER_OF_CHANNELS-1:0] r_pulse;
    logic [NUMBER_OF_CHANNELS-1:0] r_act;

    logic [NUMBER_OF_CHANNELS-1:0] w_lvl_nxt;
    logic [FILTER_CNT_WIDTH-1:0]   w_cnt_nxt [NUMBER_OF_CHANNELS];

    // Two-flop synchronizer; runs every cycle independent of the sample strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.i_channels;
            r_sync2 <= r_sync1;
        end
    end

    // Filter next state. Any sample agreeing with the current level restarts
    // the count, so a change needs FILTER_LENGTH uninterrupted disagreements.
    // The counter stops at FILTER_LENGTH-1 because the level flips there.
    always_comb begin
        w_lvl_nxt = r_lvl;
        for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end
        if (bus.i_sample_en) begin
            for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == LP_CNT_LAST) begin
                    w_lvl_nxt[i] = r_sync2[i];
                    w_cnt_nxt[i] = '0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // The strobe is registered on the same edge as the level, so it is high
    // for exactly the cycle in which o_level first reads 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lvl   <= '0;
            r_pulse <= '0;
            for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_lvl   <= w_lvl_nxt;
            r_pulse <= w_lvl_nxt & ~r_lvl;
            for (int i = 0; i < NUMBER_OF_CHANNELS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Set has priority over clear so a pulse coinciding with a clear is kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act <= '0;
        end else begin
            r_act <= (r_act & {NUMBER_OF_CHANNELS{~bus.i_act_clr}}) | r_pulse;
        end
    end

    assign bus.o_level    = r_lvl;
    assign bus.o_pulse    = r_pulse;
    assign bus.o_activity = r_act;

endmodule
